// File: rtl/traceback_ctrl_if.sv
// Traceback controller bus: the direction/sequence read ports, the aligned-RAM write ports and the run status.
// The master side drives start/lengths/read data; the slave side is the controller.
interface traceback_ctrl_if #(
    parameter int unsigned N = 128
);
    localparam int unsigned BitAddr = $clog2(N);

    logic                 start;
    logic [BitAddr:0]     len_a;
    logic [BitAddr:0]     len_b;
    logic [BitAddr:0]     i;
    logic [BitAddr:0]     j;
    logic [BitAddr-1:0]   addr_a;
    logic [BitAddr-1:0]   addr_b;
    logic [1:0]           dir_data;
    logic [1:0]           seqA_data;
    logic [1:0]           seqB_data;
    logic                 en_traceA;
    logic                 en_traceB;
    logic [BitAddr+1:0]   k;
    logic [2:0]           dataA_out;
    logic [2:0]           dataB_out;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [BitAddr+1:0]   aln_len;

    modport master (
        output start, len_a, len_b, dir_data, seqA_data, seqB_data,
        input  i, j, addr_a, addr_b, en_traceA, en_traceB, k,
               dataA_out, dataB_out, busy, done, err, aln_len
    );

    modport slave (
        input  start, len_a, len_b, dir_data, seqA_data, seqB_data,
        output i, j, addr_a, addr_b, en_traceA, en_traceB, k,
               dataA_out, dataB_out, busy, done, err, aln_len
    );
endinterface

// File: rtl/traceback_ctrl.sv
// Needleman-Wunsch traceback sequencer: walks the direction matrix from (len_a,len_b) to (0,0)
// and writes one aligned column per two-cycle step into the aligned RAMs, last column first.
module traceback_ctrl #(
    parameter int unsigned N = 128
) (
    input  logic             clk,
    input  logic             rst,
    traceback_ctrl_if.slave  tb_if
);
    localparam int unsigned BitAddr = $clog2(N);
    localparam int unsigned IW      = BitAddr + 1;
    localparam int unsigned KW      = BitAddr + 2;

    localparam logic [1:0] DIR_DIAG = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_LEFT = 2'b10;
    localparam logic [2:0] GAP      = 3'b100;

    typedef enum logic [1:0] {IDLE, READ, DECIDE, FIN} state_t;

    state_t              state_q;
    logic [IW-1:0]       i_q, j_q, i_d, j_d;
    logic [BitAddr-1:0]  addr_a_q, addr_b_q;
    logic [KW-1:0]       k_q, aln_len_q;
    logic                busy_q, done_q, err_q;
    logic [1:0]          dir_c;
    logic                wr_c;
    logic [2:0]          data_a_c, data_b_c;

    function automatic logic [BitAddr-1:0] seq_addr(input logic [IW-1:0] x);
        return (x == '0) ? '0 : BitAddr'(x - IW'(1));
    endfunction

    // Step decode: forced direction at the matrix edges, write data and the next matrix position.
    always_comb begin
        dir_c    = tb_if.dir_data;
        wr_c     = 1'b0;
        data_a_c = '0;
        data_b_c = '0;
        i_d      = i_q;
        j_d      = j_q;
        if (i_q == '0) begin
            dir_c = DIR_LEFT;
        end else if (j_q == '0) begin
            dir_c = DIR_UP;
        end
        if (state_q == DECIDE && !rst) begin
            case (dir_c)
                DIR_DIAG: begin
                    wr_c     = 1'b1;
                    data_a_c = {1'b0, tb_if.seqA_data};
                    data_b_c = {1'b0, tb_if.seqB_data};
                    i_d      = i_q - IW'(1);
                    j_d      = j_q - IW'(1);
                end
                DIR_UP: begin
                    wr_c     = 1'b1;
                    data_a_c = {1'b0, tb_if.seqA_data};
                    data_b_c = GAP;
                    i_d      = i_q - IW'(1);
                end
                DIR_LEFT: begin
                    wr_c     = 1'b1;
                    data_a_c = GAP;
                    data_b_c = {1'b0, tb_if.seqB_data};
                    j_d      = j_q - IW'(1);
                end
                default: wr_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            k_q       <= '0;
            aln_len_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tb_if.start) begin
                        i_q      <= tb_if.len_a;
                        j_q      <= tb_if.len_b;
                        addr_a_q <= seq_addr(tb_if.len_a);
                        addr_b_q <= seq_addr(tb_if.len_b);
                        k_q      <= '0;
                        err_q    <= 1'b0;
                        if (tb_if.len_a == '0 && tb_if.len_b == '0) begin
                            state_q   <= FIN;
                            done_q    <= 1'b1;
                            aln_len_q <= '0;
                        end else begin
                            state_q <= READ;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                READ: state_q <= DECIDE;
                DECIDE: begin
                    if (!wr_c) begin
                        // Invalid direction inside the matrix: abort without writing.
                        state_q   <= FIN;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        aln_len_q <= k_q;
                    end else begin
                        i_q      <= i_d;
                        j_q      <= j_d;
                        addr_a_q <= seq_addr(i_d);
                        addr_b_q <= seq_addr(j_d);
                        k_q      <= k_q + KW'(1);
                        if (i_d == '0 && j_d == '0) begin
                            state_q   <= FIN;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            aln_len_q <= k_q + KW'(1);
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tb_if.i         = i_q;
    assign tb_if.j         = j_q;
    assign tb_if.addr_a    = addr_a_q;
    assign tb_if.addr_b    = addr_b_q;
    assign tb_if.k         = k_q;
    assign tb_if.en_traceA = wr_c;
    assign tb_if.en_traceB = wr_c;
    assign tb_if.dataA_out = data_a_c;
    assign tb_if.dataB_out = data_b_c;
    assign tb_if.busy      = busy_q;
    assign tb_if.done      = done_q;
    assign tb_if.err       = err_q;
    assign tb_if.aln_len   = aln_len_q;
endmodule

// File: tb/tb_traceback_ctrl.sv
// Scoreboard bench for traceback_ctrl: directed runs push expected writes/completions,
// a negedge monitor pops and compares whenever the DUT writes or signals done.
module tb_traceback_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    traceback_ctrl_if #(.N(128)) bus ();
    traceback_ctrl #(.N(128)) dut (.clk(clk), .rst(rst), .tb_if(bus));

    logic [1:0] dirm [0:128][0:128];
    logic [1:0] seqa [0:127];
    logic [1:0] seqb [0:127];

    // Direction and sequence memories with one-cycle read latency.
    always @(posedge clk) begin
        bus.dir_data  <= dirm[bus.i][bus.j];
        bus.seqA_data <= seqa[bus.addr_a];
        bus.seqB_data <= seqb[bus.addr_b];
    end

    typedef struct { int cyc; int k; int a; int b; } wexp_t;
    typedef struct { int cyc; int aln; int err; } dexp_t;
    wexp_t wq[$];
    dexp_t dq[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.en_traceA === 1'b1 || bus.en_traceB === 1'b1) begin
            chk("en_pair", int'(bus.en_traceA), int'(bus.en_traceB));
            if (wq.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                wexp_t e;
                e = wq.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_k", int'(bus.k), e.k);
                chk("wr_dataA", int'(bus.dataA_out), e.a);
                chk("wr_dataB", int'(bus.dataB_out), e.b);
            end
        end
        if (bus.done === 1'b1) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                dexp_t d;
                d = dq.pop_front();
                chk("done_cycle", cyc, d.cyc);
                chk("aln_len", int'(bus.aln_len), d.aln);
                chk("err", int'(bus.err), d.err);
                chk("busy_at_done", int'(bus.busy), 0);
            end
        end
    end

    task automatic clear_mem();
        for (int r = 0; r <= 128; r++)
            for (int c = 0; c <= 128; c++) dirm[r][c] = 2'b00;
        for (int n = 0; n < 128; n++) begin
            seqa[n] = 2'b00;
            seqb[n] = 2'b00;
        end
    endtask

    // Returns in cycle 1 of the run with e0 = cycle counter value during cycle 1.
    task automatic start_run(input int la, input int lb, output int e0);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.len_a = 8'(la);
        bus.len_b = 8'(lb);
        e0 = cyc + 1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic push_w(input int e0, input int m, input int a, input int b);
        wexp_t e;
        e.cyc = e0 + 1 + 2 * m;
        e.k   = m;
        e.a   = a;
        e.b   = b;
        wq.push_back(e);
    endtask

    task automatic push_d(input int c, input int aln, input int err);
        dexp_t d;
        d.cyc = c;
        d.aln = aln;
        d.err = err;
        dq.push_back(d);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (bus.done === 1'b1) break;
            n++;
        end
        if (n >= 400) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_i"}, int'(bus.i), 0);
        chk({tag, "_j"}, int'(bus.j), 0);
        chk({tag, "_addr_a"}, int'(bus.addr_a), 0);
        chk({tag, "_addr_b"}, int'(bus.addr_b), 0);
        chk({tag, "_k"}, int'(bus.k), 0);
        chk({tag, "_aln_len"}, int'(bus.aln_len), 0);
        chk({tag, "_en"}, int'({bus.en_traceA, bus.en_traceB}), 0);
        chk({tag, "_data"}, int'({bus.dataA_out, bus.dataB_out}), 0);
        chk({tag, "_flags"}, int'({bus.busy, bus.done, bus.err}), 0);
    endtask

    task automatic setup_diag();
        clear_mem();
        seqa[0] = 2'd0; seqa[1] = 2'd1; seqa[2] = 2'd2;
        seqb[0] = 2'd0; seqb[1] = 2'd1; seqb[2] = 2'd2;
    endtask

    task automatic setup_boundary();
        clear_mem();
        seqa[0] = 2'd3; seqa[1] = 2'd1;
        dirm[2][0] = 2'b11;
        dirm[1][0] = 2'b11;
    endtask

    initial begin
        int e0;
        bus.start = 1'b0;
        bus.len_a = '0;
        bus.len_b = '0;
        clear_mem();

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("reset");

        // Pure diagonal 3x3.
        setup_diag();
        start_run(3, 3, e0);
        push_w(e0, 0, 3'b010, 3'b010);
        push_w(e0, 1, 3'b001, 3'b001);
        push_w(e0, 2, 3'b000, 3'b000);
        push_d(e0 + 6, 3, 0);
        chk("busy_cycle1", int'(bus.busy), 1);
        wait_done();

        // Column edge: forced up, dir_data of 11 must be ignored.
        setup_boundary();
        start_run(2, 0, e0);
        push_w(e0, 0, 3'b001, 3'b100);
        push_w(e0, 1, 3'b011, 3'b100);
        push_d(e0 + 4, 2, 0);
        wait_done();

        // Mixed path ending with a forced left on row 0.
        clear_mem();
        seqa[0] = 2'd2; seqa[1] = 2'd3;
        seqb[0] = 2'd1; seqb[1] = 2'd0; seqb[2] = 2'd3;
        dirm[2][3] = 2'b10;
        dirm[2][2] = 2'b00;
        dirm[1][1] = 2'b01;
        dirm[0][1] = 2'b11;
        start_run(2, 3, e0);
        push_w(e0, 0, 3'b100, 3'b011);
        push_w(e0, 1, 3'b011, 3'b000);
        push_w(e0, 2, 3'b010, 3'b100);
        push_w(e0, 3, 3'b100, 3'b001);
        push_d(e0 + 8, 4, 0);
        wait_done();

        // Invalid direction on the first step.
        clear_mem();
        dirm[4][4] = 2'b11;
        start_run(4, 4, e0);
        push_d(e0 + 2, 0, 1);
        wait_done();
        @(negedge clk);
        chk("err_held", int'(bus.err), 1);
        chk("done_one_cycle", int'(bus.done), 0);

        // Start pulse while busy is ignored; the next accepted start clears err.
        setup_boundary();
        start_run(2, 0, e0);
        chk("err_cleared", int'(bus.err), 0);
        push_w(e0, 0, 3'b001, 3'b100);
        push_w(e0, 1, 3'b011, 3'b100);
        push_d(e0 + 4, 2, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.len_a = 8'd5;
        bus.len_b = 8'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done();

        // Zero-length run.
        start_run(0, 0, e0);
        push_d(e0, 0, 0);
        chk("zero_busy", int'(bus.busy), 0);
        wait_done();

        // Reset during the third step's write cycle.
        setup_diag();
        start_run(3, 3, e0);
        push_w(e0, 0, 3'b010, 3'b010);
        push_w(e0, 1, 3'b001, 3'b001);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("midrst");

        // Clean run after the reset.
        start_run(3, 3, e0);
        push_w(e0, 0, 3'b010, 3'b010);
        push_w(e0, 1, 3'b001, 3'b001);
        push_w(e0, 2, 3'b000, 3'b000);
        push_d(e0 + 6, 3, 0);
        wait_done();

        repeat (3) @(negedge clk);
        chk("writes_outstanding", wq.size(), 0);
        chk("dones_outstanding", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
